// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One access issues per cycle; read data returns two cycles after the grant to the owning port.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [3:0]        we0,
  input  logic [3:0]        we1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              stall0,
  output logic              stall1,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              prio_q, prio_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic              rd1_q, rd1_d;
  logic              port1_q, port1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt0_s, gnt1_s;

  // Arbitration, issue stage and return stage next-state logic.
  always_comb begin
    gnt0_s      = reset & req0 & (~req1 | ~prio_q);
    gnt1_s      = reset & req1 & (~req0 | prio_q);
    prio_d      = prio_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd1_d       = 1'b0;
    port1_d     = 1'b0;
    if (gnt0_s) begin
      prio_d      = 1'b1;
      mem_en_d    = 1'b1;
      mem_addr_d  = addr0;
      mem_wdata_d = wdata0;
      mem_we_d    = we0;
      rd1_d       = (we0 == 4'b0000);
      port1_d     = 1'b0;
    end else if (gnt1_s) begin
      prio_d      = 1'b0;
      mem_en_d    = 1'b1;
      mem_addr_d  = addr1;
      mem_wdata_d = wdata1;
      mem_we_d    = we1;
      rd1_d       = (we1 == 4'b0000);
      port1_d     = 1'b1;
    end else begin
      prio_d = prio_q;
    end
    // The return stage lines up with mem_rdata, which is valid one cycle after mem_en.
    rvalid0_d = rd1_q & ~port1_q;
    rvalid1_d = rd1_q & port1_q;
    rdata0_d  = rvalid0_q ? mem_rdata : rdata0_q;
    rdata1_d  = rvalid1_q ? mem_rdata : rdata1_q;
    if (req0 && req1 && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_we_q    <= 4'b0000;
      rd1_q       <= 1'b0;
      port1_q     <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= {DATA_W{1'b0}};
      rdata1_q    <= {DATA_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      prio_q      <= prio_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rd1_q       <= rd1_d;
      port1_q     <= port1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt0         = gnt0_s;
  assign gnt1         = gnt1_s;
  assign stall0       = req0 & ~gnt0_s;
  assign stall1       = req1 & ~gnt1_s;
  assign mem_en       = mem_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign rvalid0      = rvalid0_q;
  assign rvalid1      = rvalid1_q;
  assign rdata0       = rdata0_d;
  assign rdata1       = rdata1_d;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of all address ports.
REQ-002 Parameter: DATA_W, 32, data width of all data ports.
REQ-003 Parameter: CNT_W, 16, width of conflict counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req0 / req1  input  1  per-port access request; held by requester until granted.
REQ-007 addr0 / addr1  input  ADDR_W  per-port byte address.
REQ-008 wdata0 / wdata1  input  DATA_W  per-port write data.
REQ-009 we0 / we1  input  4  per-port byte write enables; all-zero = read.
REQ-010 gnt0 / gnt1  output  1  combinational grant, same cycle as request.
REQ-011 rdata0 / rdata1  output  DATA_W  read data returned to port.
REQ-012 rvalid0 / rvalid1  output  1  one-cycle pulse, rdataN valid.
REQ-013 stall0 / stall1  output  1  reqN high and gntN low this cycle.
REQ-014 mem_en  output  1  registered memory access strobe.
REQ-015 mem_addr  output  ADDR_W  registered memory byte address.
REQ-016 mem_wdata  output  DATA_W  registered memory write data.
REQ-017 mem_we  output  4  registered memory byte enables.
REQ-018 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en.
REQ-019 conflict_cnt  output  CNT_W  count of cycles with req0 and req1 both high.

Function
REQ-020 Arbiter SHALL grant at most one port per cycle; gnt0 and gnt1 never both high.
REQ-021 Single requester SHALL be granted in the same cycle, regardless of priority pointer.
REQ-022 Both requesting: port selected by 1-bit round-robin pointer prio (0 = port0 wins).
REQ-023 prio SHALL update only on a grant: prio <= ~granted_port; no grant leaves prio unchanged.
REQ-024 Cycle T grant: at T+1 mem_en=1, mem_addr/mem_wdata/mem_we = granted port's values sampled at T.
REQ-025 Cycle with no grant: next cycle mem_en=0, mem_we=0; mem_addr/mem_wdata hold last values.
REQ-026 Throughput: one access per cycle sustained; no idle cycles between back-to-back grants.
REQ-027 Issue pipeline SHALL carry a tag {valid_read, port}; valid_read = grant with we==0.
REQ-028 Read granted at T: rvalidN=1 at T+2, rdataN = mem_rdata at T+2; other port's rvalid 0.
REQ-029 Write grant SHALL produce no rvalid pulse; memory handles byte-enable merging.
REQ-030 rdataN SHALL hold its last returned value when rvalidN is low.
REQ-031 Up to two reads in flight (T+1, T+2 stages); ordering preserved, one return per cycle.
REQ-032 Port dropping req without grant: request discarded, no state change, no error.
REQ-033 conflict_cnt SHALL increment by 1 each cycle req0&req1 both high, saturating at all-ones.
REQ-034 stallN SHALL be combinational: reqN & ~gntN.

Reset
REQ-035 reset low SHALL asynchronously clear: prio=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, pipeline tags invalid, rvalid0=rvalid1=0, rdata0=rdata1=0, conflict_cnt=0.
REQ-036 During reset gnt0=gnt1=0 regardless of req inputs.
REQ-037 Reset mid-operation SHALL drop in-flight reads; no rvalid after deassertion for pre-reset grants.
REQ-038 First cycle after reset deasserts: normal arbitration, prio=0 (port0 wins a tie).

Verification
REQ-039 Single read: req0=1, addr0=0x40, we0=0 at T, mem_rdata=0xDEADBEEF at T+2 -> gnt0=1 at T, mem_en=1/mem_addr=0x40 at T+1, rvalid0=1/rdata0=0xDEADBEEF at T+2.
REQ-040 Tie alternation: req0=req1=1 held 4 cycles after reset, all reads -> grants 0,1,0,1; stall toggles opposite; conflict_cnt=4.
REQ-041 Write: req1=1, addr1=0x10, wdata1=0x12345678, we1=0b0011 -> mem_we=0b0011, mem_wdata=0x12345678 at T+1; no rvalid1.
REQ-042 Back-to-back mixed: port0 read 0x0, port1 read 0x4 on consecutive cycles -> mem_en high two consecutive cycles, rvalid0 then rvalid1 in consecutive cycles with matching data.
REQ-043 Reset mid-flight: read granted at T, reset low at T+1 for 1 cycle -> rvalid0 never asserted, all outputs at reset values, conflict_cnt=0.
REQ-044 Saturation: CNT_W=4, both requesting 20 cycles -> conflict_cnt stops at 15.
